// File: rtl/registro_serie_paralelo_pkg.sv
// Shared types and constants for the serial-to-parallel receive register.
// Build option SERIE_PARALELO_PARITY_EN adds a trailing even-parity bit per frame.
package serie_paralelo_pkg;

   localparam int DEF_WIDTH = 4;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_PARITY  = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = S_IDLE,
      COLLECT = S_COLLECT,
      PARITY  = S_PARITY
   } state_t;

   // Bit counter must be able to hold WIDTH itself (parity frames park there).
   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/registro_serie_paralelo_if.sv
// Serial input / parallel output bundle of the receive register.
// parity_err exists only when SERIE_PARALELO_PARITY_EN is defined.
interface registro_serie_paralelo_if #(parameter int WIDTH = serie_paralelo_pkg::DEF_WIDTH);

   logic             bit_in;
   logic             bit_valid;
   logic             frame_start;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             data_ack;
   logic             overrun;
   logic             overrun_clr;
   logic             busy;
`ifdef SERIE_PARALELO_PARITY_EN
   logic             parity_err;
`endif

   modport master (
      output bit_in, bit_valid, frame_start, data_ack, overrun_clr,
`ifdef SERIE_PARALELO_PARITY_EN
      input  parity_err,
`endif
      input  data_out, data_valid, overrun, busy
   );

   modport slave (
      input  bit_in, bit_valid, frame_start, data_ack, overrun_clr,
`ifdef SERIE_PARALELO_PARITY_EN
      output parity_err,
`endif
      output data_out, data_valid, overrun, busy
   );

endinterface

// File: rtl/registro_serie_paralelo_retencion_salida.sv
// Output holding register: valid/ack handshake plus sticky overrun on dropped words.
// With SERIE_PARALELO_PARITY_EN the parity error flag is held alongside the word.
module retencion_salida #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             word_done,
   input  logic [WIDTH-1:0] word,
`ifdef SERIE_PARALELO_PARITY_EN
   input  logic             word_perr,
   output logic             parity_err,
`endif
   input  logic             data_ack,
   input  logic             overrun_clr,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             overrun
);

   logic load;
   logic drop;

   // A word may land in the same cycle the consumer frees the slot.
   assign load = word_done && (!data_valid || data_ack);
   assign drop = word_done && data_valid && !data_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
`ifdef SERIE_PARALELO_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else if (load) begin
         data_out   <= word;
         data_valid <= 1'b1;
`ifdef SERIE_PARALELO_PARITY_EN
         parity_err <= word_perr;
`endif
      end else if (data_ack) begin
         data_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/registro_serie_paralelo.sv
// Serial-to-parallel receive register: LSB-first bit collector feeding a holding register.
// Define SERIE_PARALELO_PARITY_EN to expect an even-parity bit after each word.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no bits held, count = 0
// COLLECT | 1..WIDTH-1 data bits held
// PARITY  | all data bits held, waiting for parity bit
module registro_serie_paralelo
   import serie_paralelo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic                   clk,
   input logic                   rst,
   registro_serie_paralelo_if.slave bus
);

   localparam int CW = count_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SERIE_PARALELO_PARITY_EN
   localparam int SR_W = WIDTH;
`else
   // The final bit goes straight into the word, so one fewer bit needs storing.
   localparam int SR_W = WIDTH - 1;
`endif

   state_t           state;
   logic [CW-1:0]    count;
   logic [SR_W-1:0]  shift_reg;
   logic [SR_W-1:0]  shift_next;
   logic [SR_W-1:0]  shift_fs;
   logic [WIDTH-1:0] word;
   logic             word_done;
`ifdef SERIE_PARALELO_PARITY_EN
   logic             word_perr;
`endif

   always_comb begin
      shift_fs           = '0;
      shift_fs[SR_W-1]   = bus.bit_in;
`ifdef SERIE_PARALELO_PARITY_EN
      word       = shift_reg;
      word_perr  = ^{shift_reg, bus.bit_in};
      shift_next = {bus.bit_in, shift_reg[SR_W-1:1]};
      word_done  = bus.bit_valid && !bus.frame_start && (state == PARITY);
`else
      word       = {bus.bit_in, shift_reg};
      shift_next = word[WIDTH-1:1];
      word_done  = bus.bit_valid && !bus.frame_start && (state == COLLECT) && (count == LAST);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         shift_reg <= '0;
      end else if (bus.bit_valid) begin
         if (bus.frame_start) begin
            shift_reg <= shift_fs;
            count     <= CW'(1);
            state     <= COLLECT;
         end else if (word_done) begin
            count <= '0;
            state <= IDLE;
         end else begin
            shift_reg <= shift_next;
            count     <= count + 1'b1;
`ifdef SERIE_PARALELO_PARITY_EN
            state     <= (count == LAST) ? PARITY : COLLECT;
`else
            state     <= COLLECT;
`endif
         end
      end else if (bus.frame_start) begin
         shift_reg <= '0;
         count     <= '0;
         state     <= IDLE;
      end
   end

   assign bus.busy = (count != '0);

   retencion_salida #(.WIDTH(WIDTH)) u_retencion (
      .clk         (clk),
      .rst         (rst),
      .word_done   (word_done),
      .word        (word),
`ifdef SERIE_PARALELO_PARITY_EN
      .word_perr   (word_perr),
      .parity_err  (bus.parity_err),
`endif
      .data_ack    (bus.data_ack),
      .overrun_clr (bus.overrun_clr),
      .data_out    (bus.data_out),
      .data_valid  (bus.data_valid),
      .overrun     (bus.overrun)
   );

endmodule

// File: tb/tb_registro_serie_paralelo.sv
// Directed bench for registro_serie_paralelo (WIDTH=4); covers the parity frame
// as well when SERIE_PARALELO_PARITY_EN is defined.
module tb_registro_serie_paralelo;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   registro_serie_paralelo_if #(.WIDTH(4)) bus ();

   registro_serie_paralelo #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      bus.bit_valid = 1'b1;
      bus.bit_in    = b;
      tick();
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'b0;
   endtask

   // Last data bit plus, in parity builds, the matching even-parity bit.
   task automatic last_bits(input logic [3:0] w);
      drive_bit(w[3]);
`ifdef SERIE_PARALELO_PARITY_EN
      drive_bit(^w);
`endif
   endtask

   task automatic send_word(input logic [3:0] w);
      for (int i = 0; i < 3; i++) drive_bit(w[i]);
      last_bits(w);
   endtask

   task automatic ack_once();
      bus.data_ack = 1'b1;
      tick();
      bus.data_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (bus.data_out !== 4'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.data_out); end
      checks++;
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.data_valid); end
      checks++;
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
`ifdef SERIE_PARALELO_PARITY_EN
      checks++;
      if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", bus.parity_err); end
`endif
   endtask

   task automatic test_basic();
      logic [3:0] w;
      w = 4'hB;
      for (int i = 0; i < 3; i++) begin
         drive_bit(w[i]);
         checks++;
         if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy bit %0d got %b exp 1", i, bus.busy); end
         checks++;
         if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid bit %0d got %b exp 0", i, bus.data_valid); end
      end
      last_bits(w);
      checks++;
      if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.data_valid); end
      checks++;
      if (bus.data_out !== 4'hB) begin errors++; $display("FAIL basic_data got %h exp b", bus.data_out); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", bus.busy); end
      ack_once();
      checks++;
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid got %b exp 0", bus.data_valid); end
      checks++;
      if (bus.data_out !== 4'hB) begin errors++; $display("FAIL basic_ack_hold got %h exp b", bus.data_out); end
      ack_once();
      checks++;
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_valid got %b exp 0", bus.data_valid); end
   endtask

   task automatic test_back_to_back();
      send_word(4'hB);
      checks++;
      if (bus.data_out !== 4'hB || bus.data_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_first got %h/%b exp b/1", bus.data_out, bus.data_valid);
      end
      bus.data_ack = 1'b1;
      drive_bit(1'b0);
      bus.data_ack = 1'b0;
      checks++;
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack got %b exp 0", bus.data_valid); end
      drive_bit(1'b1);
      drive_bit(1'b1);
      last_bits(4'h6);
      checks++;
      if (bus.data_out !== 4'h6 || bus.data_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_second got %h/%b exp 6/1", bus.data_out, bus.data_valid);
      end
      checks++;
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", bus.overrun); end
      ack_once();
   endtask

   task automatic test_overrun();
      send_word(4'hB);
      send_word(4'h3);
      checks++;
      if (bus.data_out !== 4'hB) begin errors++; $display("FAIL ovr_data got %h exp b", bus.data_out); end
      checks++;
      if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", bus.data_valid); end
      checks++;
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", bus.overrun); end
      bus.overrun_clr = 1'b1;
      bus.data_ack    = 1'b1;
      tick();
      bus.overrun_clr = 1'b0;
      bus.data_ack    = 1'b0;
      checks++;
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", bus.overrun); end
      checks++;
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid got %b exp 0", bus.data_valid); end
      // overrun set and clear in the same cycle: set wins
      send_word(4'h5);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      bus.overrun_clr = 1'b1;
      last_bits(4'hA);
      bus.overrun_clr = 1'b0;
      checks++;
      if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", bus.overrun); end
      checks++;
      if (bus.data_out !== 4'h5) begin errors++; $display("FAIL ovr_keep_data got %h exp 5", bus.data_out); end
      bus.overrun_clr = 1'b1;
      tick();
      bus.overrun_clr = 1'b0;
      checks++;
      if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr2 got %b exp 0", bus.overrun); end
      // ack landing with the completing bit replaces the word without overrun
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      bus.data_ack = 1'b1;
      last_bits(4'h9);
      bus.data_ack = 1'b0;
      checks++;
      if (bus.data_out !== 4'h9 || bus.data_valid !== 1'b1 || bus.overrun !== 1'b0) begin
         errors++; $display("FAIL ack_on_complete got %h/%b/%b exp 9/1/0", bus.data_out, bus.data_valid, bus.overrun);
      end
      ack_once();
   endtask

   task automatic test_frame_start();
      drive_bit(1'b1);
      drive_bit(1'b0);
      bus.frame_start = 1'b1;
      drive_bit(1'b1);
      bus.frame_start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL fs_busy got %b exp 1", bus.busy); end
      drive_bit(1'b0);
      drive_bit(1'b0);
      checks++;
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL fs_early got %b exp 0", bus.data_valid); end
      last_bits(4'h9);
      checks++;
      if (bus.data_out !== 4'h9 || bus.data_valid !== 1'b1) begin
         errors++; $display("FAIL fs_data got %h/%b exp 9/1", bus.data_out, bus.data_valid);
      end
      ack_once();
      drive_bit(1'b1);
      drive_bit(1'b1);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL fs_alone_busy got %b exp 0", bus.busy); end
      checks++;
      if (bus.data_valid !== 1'b0 || bus.data_out !== 4'h9) begin
         errors++; $display("FAIL fs_alone_out got %h/%b exp 9/0", bus.data_out, bus.data_valid);
      end
      send_word(4'h6);
      checks++;
      if (bus.data_out !== 4'h6 || bus.data_valid !== 1'b1) begin
         errors++; $display("FAIL fs_realign got %h/%b exp 6/1", bus.data_out, bus.data_valid);
      end
      ack_once();
   endtask

   task automatic test_reset_mid_word();
      drive_bit(1'b1);
      drive_bit(1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.data_valid !== 1'b0 || bus.data_out !== 4'h0) begin
         errors++; $display("FAIL rst_mid got busy %b valid %b data %h exp 0/0/0", bus.busy, bus.data_valid, bus.data_out);
      end
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      checks++;
      if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL rst_spurious got %b exp 0", bus.data_valid); end
      last_bits(4'hF);
      checks++;
      if (bus.data_out !== 4'hF || bus.data_valid !== 1'b1) begin
         errors++; $display("FAIL rst_new_word got %h/%b exp f/1", bus.data_out, bus.data_valid);
      end
      ack_once();
   endtask

`ifdef SERIE_PARALELO_PARITY_EN
   task automatic test_parity();
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      checks++;
      if (bus.busy !== 1'b1 || bus.data_valid !== 1'b0) begin
         errors++; $display("FAIL par_wait got busy %b valid %b exp 1/0", bus.busy, bus.data_valid);
      end
      drive_bit(1'b1);
      checks++;
      if (bus.data_out !== 4'hB || bus.data_valid !== 1'b1 || bus.parity_err !== 1'b0) begin
         errors++; $display("FAIL par_good got %h/%b/%b exp b/1/0", bus.data_out, bus.data_valid, bus.parity_err);
      end
      ack_once();
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      checks++;
      if (bus.data_out !== 4'hB || bus.data_valid !== 1'b1 || bus.parity_err !== 1'b1) begin
         errors++; $display("FAIL par_bad got %h/%b/%b exp b/1/1", bus.data_out, bus.data_valid, bus.parity_err);
      end
      ack_once();
   endtask
`endif

   initial begin
      rst             = 1'b1;
      bus.bit_in      = 1'b0;
      bus.bit_valid   = 1'b0;
      bus.frame_start = 1'b0;
      bus.data_ack    = 1'b0;
      bus.overrun_clr = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_overrun();
      test_frame_start();
      test_reset_mid_word();
`ifdef SERIE_PARALELO_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/registro_serie_paralelo.md
Name: registro_serie_paralelo

Overview:
- Serial-to-parallel receive register. Sits directly downstream of the parallel-to-serial transmitter.
- Accepts one qualified bit per cycle, LSB first, and assembles WIDTH-bit words.
- Presents each completed word in an output holding register with a valid/ack handshake and a sticky overrun flag.

Parameters:
- WIDTH, 4, data word width in bits (>= 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled this cycle.
- frame_start  input  1  discards any partial word; realigns to a word boundary.
- data_out  output  WIDTH  assembled word; bit 0 = first bit received.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ack  input  1  consumer takes data_out this cycle.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  clears overrun.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- One clock (clk); reset synchronous, active-high. rst sampled high at a clk edge clears all state.
- Reset values: data_out=0, data_valid=0, overrun=0, busy=0, internal shift register=0, bit count=0, FSM=IDLE.
- FSM states: IDLE (count 0) and COLLECT (1..WIDTH-1 bits held).
  - IDLE -> COLLECT on bit_valid.
  - COLLECT -> IDLE on the WIDTH-th accepted bit, or on frame_start without bit_valid.
- Bit accept: shift_reg <= {bit_in, shift_reg[WIDTH-1:1]}; count increments. Count width is clog2(WIDTH+1).
- Word completion: on the cycle the WIDTH-th bit is accepted, the word is {bit_in, shift_reg[WIDTH-1:1]}. Count returns to 0.
  - If data_valid=0, or data_valid=1 with data_ack=1 in the same cycle: data_out <= word and data_valid=1 from the next cycle.
  - Otherwise the word is dropped, data_out is unchanged, and overrun <= 1.
- Latency: data_valid rises exactly 1 cycle after the last bit's bit_valid cycle. Back-to-back words with no gap are supported.
- data_ack while data_valid=1 and no new word completes: data_valid <= 0 next cycle. data_out retains its value.
- data_ack while data_valid=0: ignored.
- frame_start: count and shift_reg cleared.
  - With simultaneous bit_valid, that bit becomes bit 0 of a new word (count=1).
  - No effect on data_out, data_valid or overrun.
- overrun: sticky until overrun_clr or rst. If set and clear occur in the same cycle, set wins.
- busy = (count != 0), registered state, no combinational path from inputs.
- rst asserted mid-word: the partial word is lost and no data_valid is produced for it.

Optional Feature:
- Macro: SERIE_PARALELO_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit, giving a WIDTH+1 bit frame. The FSM gains a PARITY state after bit WIDTH-1.
  - Completion and overrun logic apply on the parity bit's cycle.
  - Adds output port parity_err (1 bit, reset 0), loaded together with data_out: 1 if XOR(word, parity bit) = 1.
  - The word is delivered even when parity_err=1.
- Undefined: no parity bit, no PARITY state, no parity_err port. Frame = WIDTH bits.

Decomposition:
- Package serie_paralelo_pkg: FSM state typedef (IDLE, COLLECT, PARITY), default width constant (4), count-width function.
- One natural sub-module, retencion_salida: output holding register with valid/ack, overrun detection and sticky flag.
- Collector FSM and shift register stay in the top module.

Test Plan:
- Reset then bits 1,1,0,1 on consecutive bit_valid cycles -> data_out=4'hB, data_valid=1 on the cycle after the 4th bit; busy high for 3 cycles.
- Two back-to-back words 4'hB then 4'h6 (bits 0,1,1,0), data_ack pulsed the cycle data_valid rises -> data_out=4'hB then 4'h6, overrun=0.
- Word 4'hB with no ack, then word 4'h3 -> data_out stays 4'hB, overrun=1. Then overrun_clr and data_ack in the same cycle -> overrun=0, data_valid=0 next cycle.
- Bits 1,0 then frame_start together with bit_valid bit_in=1, then 0,0,1 -> data_out=4'h9. Partial bits discarded.
- rst high after 2 bits, then 4 bits 1,1,1,1 -> no spurious data_valid; data_out=4'hF only after the full new word.
- With SERIE_PARALELO_PARITY_EN: bits 1,1,0,1 + parity 1 -> data_out=4'hB, parity_err=0. Same frame with parity 0 -> parity_err=1.
